// File: rtl/bounce_emulator_pkg.sv
// Shared definitions for the bounce emulator: LFSR constants, channel FSM
// states and the per-channel debug view.
package bounce_emulator_pkg;

  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  typedef enum logic {
    CH_IDLE   = 1'b0,
    CH_BOUNCE = 1'b1
  } ch_state_e;

  typedef struct packed {
    ch_state_e state;
    logic      target;
    logic      out;
  } ch_dbg_t;

  function automatic int log2_ceil(input int value);
    return $clog2(value);
  endfunction

  // Galois form: shift right, fold the tap mask in when a one falls out.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/bounce_emulator_lfsr16.sv
// Free-running 16-bit Galois LFSR shared by all bounce channels.
module lfsr16
  import bounce_emulator_pkg::*;
#(
  parameter logic [15:0] seed = LFSR_DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] state
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= seed;
    else     state <= lfsr_next(state);
  end

endmodule

// File: rtl/bounce_emulator.sv
// Drives deliberately bouncy copies of clean levels: each accepted edge opens a
// window of pseudo-random toggles before the output settles on the new level.
module bounce_emulator
  import bounce_emulator_pkg::*;
#(
  parameter int          width                = 1,
  parameter int          bounce_cycles        = 2000,
  parameter int          toggle_interval_max  = 64,
  parameter logic [15:0] lfsr_seed            = LFSR_DEFAULT_SEED,
  parameter int          bounce_counter_width = log2_ceil(bounce_cycles + 1),
  parameter int          interval_width       = log2_ceil(toggle_interval_max)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [width-1:0] clean_signal,
  output logic [width-1:0] bouncy_signal,
  output logic [width-1:0] bouncing
);

  localparam logic [bounce_counter_width-1:0] BC_LOAD = bounce_counter_width'(bounce_cycles);
  localparam logic [bounce_counter_width-1:0] BC_ONE  = bounce_counter_width'(1);
  localparam logic [interval_width:0]         TC_ONE  = (interval_width + 1)'(1);

  logic [15:0] lfsr_state;

  // Per-channel state, observable for bound checkers.
  ch_dbg_t [width-1:0] chan_dbg;

  lfsr16 #(.seed(lfsr_seed)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .state (lfsr_state)
  );

  for (genvar i = 0; i < width; i++) begin : g_ch
    localparam int ROT = (3 * i) % 16;

    ch_state_e                     state_q, state_d;
    logic                          target_q, target_d;
    logic                          out_q, out_d;
    logic [bounce_counter_width-1:0] bctr_q, bctr_d;
    logic [interval_width:0]       tctr_q, tctr_d;
    logic [interval_width-1:0]     draw;
    logic [interval_width:0]       interval;

    // Low bits of the LFSR rotated right by 3*i, so channels draw differently.
    always_comb begin
      draw = '0;
      for (int b = 0; b < interval_width; b++) begin
        draw[b] = lfsr_state[4'((b + ROT) % 16)];
      end
    end

    assign interval = {1'b0, draw} + TC_ONE;

    always_comb begin
      state_d  = state_q;
      target_d = target_q;
      out_d    = out_q;
      bctr_d   = bctr_q;
      tctr_d   = tctr_q;
      if (!enable) begin
        state_d  = CH_IDLE;
        target_d = clean_signal[i];
        out_d    = clean_signal[i];
      end else if (state_q == CH_IDLE) begin
        if (clean_signal[i] != target_q) begin
          state_d  = CH_BOUNCE;
          target_d = clean_signal[i];
          out_d    = clean_signal[i];
          bctr_d   = BC_LOAD;
          tctr_d   = interval;
        end
      end else begin
        if (tctr_q == TC_ONE) begin
          out_d  = ~out_q;
          tctr_d = interval;
        end else begin
          tctr_d = tctr_q - TC_ONE;
        end
        // A retrigger restarts the window; otherwise the window end wins over a toggle.
        if (clean_signal[i] != target_q) begin
          target_d = clean_signal[i];
          bctr_d   = BC_LOAD;
        end else if (bctr_q == BC_ONE) begin
          out_d   = target_q;
          state_d = CH_IDLE;
        end else begin
          bctr_d = bctr_q - BC_ONE;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q  <= CH_IDLE;
        target_q <= 1'b0;
        out_q    <= 1'b0;
        bctr_q   <= '0;
        tctr_q   <= '0;
      end else begin
        state_q  <= state_d;
        target_q <= target_d;
        out_q    <= out_d;
        bctr_q   <= bctr_d;
        tctr_q   <= tctr_d;
      end
    end

    assign bouncy_signal[i] = out_q;
    assign bouncing[i]      = (state_q == CH_BOUNCE);
    assign chan_dbg[i]      = '{state: state_q, target: target_q, out: out_q};
  end

  // LFSR bits no channel draws, and the debug view, have no other reader here.
  logic unused_bits;
  assign unused_bits = ^{lfsr_state, chan_dbg};

endmodule

// File: tb/tb_bounce_emulator.sv
// Directed bench for bounce_emulator: reset, pass-through, bounce window,
// retrigger, async reset, enable abort, channel isolation and determinism.
module tb_bounce_emulator;

  localparam int BC  = 100;
  localparam int TIM = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       clean;
  logic       bouncy, bouncing;
  logic       bouncy_twin, bouncing_twin;
  logic       bouncy_alt, bouncing_alt;
  logic [3:0] clean_w, bouncy_w, bouncing_w;

  int checks = 0;
  int passed = 0;
  int twin_diff = 0;
  int alt_diff = 0;

  logic       exp_q[$];
  logic       bs[600];
  logic       bg[600];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  bounce_emulator #(.width(1), .bounce_cycles(BC), .toggle_interval_max(TIM),
                    .lfsr_seed(16'hACE1)) u_dut (
    .clk(clk), .rst(rst), .enable(en), .clean_signal(clean),
    .bouncy_signal(bouncy), .bouncing(bouncing));

  bounce_emulator #(.width(1), .bounce_cycles(BC), .toggle_interval_max(TIM),
                    .lfsr_seed(16'hACE1)) u_twin (
    .clk(clk), .rst(rst), .enable(en), .clean_signal(clean),
    .bouncy_signal(bouncy_twin), .bouncing(bouncing_twin));

  bounce_emulator #(.width(1), .bounce_cycles(BC), .toggle_interval_max(TIM),
                    .lfsr_seed(16'h0001)) u_alt (
    .clk(clk), .rst(rst), .enable(en), .clean_signal(clean),
    .bouncy_signal(bouncy_alt), .bouncing(bouncing_alt));

  bounce_emulator #(.width(4), .bounce_cycles(BC), .toggle_interval_max(TIM),
                    .lfsr_seed(16'hACE1)) u_wide (
    .clk(clk), .rst(rst), .enable(en), .clean_signal(clean_w),
    .bouncy_signal(bouncy_w), .bouncing(bouncing_w));

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bouncy_twin !== bouncy) twin_diff++;
      if (bouncy_alt !== bouncy) alt_diff++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] m;
    logic [15:0] pt_vec;
    int lfsr_bad, hi_cnt, toggles, max_gap, last_chg, unstable, other_bad;

    rst = 1'b1; en = 1'b1; clean = 1'b0; clean_w = 4'b0000;
    repeat (3) @(negedge clk);
    check("rst_bouncy", bouncy, 0);
    check("rst_bouncing", bouncing, 0);
    check("rst_lfsr", u_dut.u_lfsr.state, 16'hACE1);
    rst = 1'b0;

    m = 16'hACE1;
    lfsr_bad = 0;
    repeat (40) begin
      @(negedge clk);
      m = m[0] ? ((m >> 1) ^ 16'hB400) : (m >> 1);
      if (u_dut.u_lfsr.state !== m) lfsr_bad++;
    end
    check("lfsr_seq", lfsr_bad, 0);

    // Pass-through: one cycle of latency, no bounce.
    en = 1'b0;
    @(negedge clk);
    clean = 1'b1;
    check("pt_before_edge", bouncy, 0);
    @(negedge clk);
    check("pt_rise", bouncy, 1);
    check("pt_no_bounce", bouncing, 0);
    pt_vec = 16'b0110_1001_1100_0101;
    for (int j = 0; j < 16; j++) begin
      clean = pt_vec[j];
      exp_q.push_back(pt_vec[j]);
      @(negedge clk);
      check("pt_follow", bouncy, exp_q.pop_front());
      check("pt_bouncing", bouncing, 0);
    end
    clean = 1'b0;
    @(negedge clk);
    en = 1'b1;
    repeat (5) @(negedge clk);
    check("reenable_no_window", bouncing, 0);
    check("reenable_level", bouncy, 0);

    // Bounce window after a 0->1 edge.
    clean = 1'b1;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      bs[n] = bouncy;
      bg[n] = bouncing;
    end
    hi_cnt = 0; toggles = 0; max_gap = 0; last_chg = 0; unstable = 0;
    for (int n = 0; n < 600; n++) if (bg[n]) hi_cnt++;
    for (int n = 1; n < BC; n++) begin
      if (bs[n] != bs[n-1]) begin
        toggles++;
        if (n - last_chg > max_gap) max_gap = n - last_chg;
        last_chg = n;
      end
    end
    for (int n = BC; n < 600; n++) if (bs[n] !== 1'b1) unstable++;
    check("win_first_contact", bs[0], 1);
    check("win_high_count", hi_cnt, BC);
    check("win_last_high", bg[BC-1], 1);
    check("win_drop", bg[BC], 0);
    check("win_toggled", toggles > 0, 1);
    check("win_gap_le_max", max_gap <= TIM, 1);
    check("win_settled", unstable, 0);

    // Retrigger at k+50 extends the window to k+150.
    clean = 1'b0;
    repeat (110) @(negedge clk);
    clean = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      bs[n] = bouncy;
      bg[n] = bouncing;
      if (n == 49) clean = 1'b0;
    end
    hi_cnt = 0; unstable = 0;
    for (int n = 0; n < 300; n++) if (bg[n]) hi_cnt++;
    for (int n = 150; n < 300; n++) if (bs[n] !== 1'b0) unstable++;
    check("rt_first_contact", bs[0], 1);
    check("rt_high_count", hi_cnt, 150);
    check("rt_last_high", bg[149], 1);
    check("rt_drop", bg[150], 0);
    check("rt_final_low", unstable, 0);

    // Asynchronous reset in the middle of a window.
    clean = 1'b1;
    repeat (20) @(negedge clk);
    check("pre_rst_bouncing", bouncing, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_bouncy", bouncy, 0);
    check("async_rst_bouncing", bouncing, 0);
    @(negedge clk);
    rst = 1'b0;
    check("post_rst_lfsr", u_dut.u_lfsr.state, 16'hACE1);
    @(negedge clk);
    check("post_rst_new_window", bouncing, 1);

    // Dropping enable aborts the window on the next edge.
    repeat (10) @(negedge clk);
    check("pre_abort_bouncing", bouncing, 1);
    en = 1'b0;
    @(negedge clk);
    check("abort_bouncing", bouncing, 0);
    check("abort_level", bouncy, 1);
    en = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_reenable_idle", bouncing, 0);

    // Four channels, only channel 2 moves.
    clean_w = 4'b0100;
    other_bad = 0; hi_cnt = 0;
    for (int n = 0; n < 150; n++) begin
      @(negedge clk);
      if ({bouncy_w[3], bouncy_w[1:0]} !== 3'b000) other_bad++;
      if ({bouncing_w[3], bouncing_w[1:0]} !== 3'b000) other_bad++;
      if (bouncing_w[2]) hi_cnt++;
    end
    check("wide_others_quiet", other_bad, 0);
    check("wide_ch2_window", hi_cnt, BC);
    check("wide_ch2_final", bouncy_w, 4'b0100);

    check("twin_identical", twin_diff, 0);
    check("alt_seed_differs", alt_diff > 0, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
